// File: rtl/aes_128_issue_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_128_issue_sched_if : requester, core and status bundle for the       |
// | two-channel AES issue scheduler.                       Rev 1.0           |
// +--------------------------------------------------------------------------+
interface aes_128_issue_sched_if #(
  parameter int MAX_INFLIGHT = 8
);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;

  logic           in_valid_0;
  logic           in_valid_1;
  logic [127:0]   in_data_0;
  logic [127:0]   in_data_1;
  logic           in_ready_0;
  logic           in_ready_1;
  logic           key_ready;
  logic           core_in_en;
  logic [127:0]   core_in_data;
  logic           core_out_en;
  logic [127:0]   core_out_data;
  logic           core_coll_irq;
  logic           out_valid_0;
  logic           out_valid_1;
  logic [127:0]   out_data;
  logic [IW-1:0]  inflight;
  logic [7:0]     coll_cnt;
  logic           coll_clr;
  logic           orphan_err;

  modport master (
    output in_valid_0, in_valid_1, in_data_0, in_data_1, key_ready,
           core_out_en, core_out_data, core_coll_irq, coll_clr,
    input  in_ready_0, in_ready_1, core_in_en, core_in_data,
           out_valid_0, out_valid_1, out_data, inflight, coll_cnt, orphan_err
  );

  modport slave (
    input  in_valid_0, in_valid_1, in_data_0, in_data_1, key_ready,
           core_out_en, core_out_data, core_coll_irq, coll_clr,
    output in_ready_0, in_ready_1, core_in_en, core_in_data,
           out_valid_0, out_valid_1, out_data, inflight, coll_cnt, orphan_err
  );
endinterface
`default_nettype wire

// File: rtl/aes_128_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | aes_128_issue_sched : round-robin, rate-paced issue of two channels into |
// | the AES core with in-order tagged result return.       Rev 1.0           |
// +--------------------------------------------------------------------------+
module aes_128_issue_sched #(
  parameter int ISSUE_GAP    = 12,
  parameter int MAX_INFLIGHT = 8
) (
  input  wire logic            clk,
  input  wire logic            kill,
  aes_128_issue_sched_if.slave bus
);
  localparam int IW = $clog2(MAX_INFLIGHT) + 1;
  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int GW = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
  localparam logic [GW-1:0] GAP_RELOAD = GW'(ISSUE_GAP - 1);
  localparam logic [IW-1:0] FIFO_FULL  = IW'(MAX_INFLIGHT);

  logic [GW-1:0]  gap_q, gap_d;
  logic           rr_last_q, rr_last_d;
  logic [IW-1:0]  cnt_q, cnt_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic           tag_q [MAX_INFLIGHT];
  logic           cin_en_q, cin_en_d;
  logic [127:0]   cin_data_q, cin_data_d;
  logic           ov0_q, ov0_d;
  logic           ov1_q, ov1_d;
  logic [127:0]   odata_q, odata_d;
  logic [7:0]     coll_q, coll_d;
  logic           orphan_q, orphan_d;

  logic           can_issue;
  logic           grant_0;
  logic           grant_1;
  logic           push;
  logic           pop;
  logic           pop_tag;

  always_comb begin
    // kill gates the handshake so in_ready drops in the same cycle as the reset.
    can_issue = bus.key_ready & (gap_q == '0) & (cnt_q < FIFO_FULL)
              & (bus.in_valid_0 | bus.in_valid_1) & ~kill;
    grant_1   = bus.in_valid_1 & (~bus.in_valid_0 | ~rr_last_q);
    grant_0   = bus.in_valid_0 & ~grant_1;
    push      = can_issue;
    pop       = bus.core_out_en & (cnt_q != '0);
    pop_tag   = tag_q[rd_ptr_q];
  end

  always_comb begin
    gap_d      = (gap_q != '0) ? gap_q - GW'(1) : gap_q;
    rr_last_d  = rr_last_q;
    cin_en_d   = 1'b0;
    cin_data_d = cin_data_q;
    wr_ptr_d   = wr_ptr_q;
    if (push) begin
      gap_d      = GAP_RELOAD;
      rr_last_d  = grant_1;
      cin_en_d   = 1'b1;
      cin_data_d = grant_1 ? bus.in_data_1 : bus.in_data_0;
      wr_ptr_d   = wr_ptr_q + PW'(1);
    end
  end

  always_comb begin
    ov0_d    = 1'b0;
    ov1_d    = 1'b0;
    odata_d  = odata_q;
    rd_ptr_d = rd_ptr_q;
    orphan_d = orphan_q | (bus.core_out_en & (cnt_q == '0));
    if (pop) begin
      ov0_d    = ~pop_tag;
      ov1_d    = pop_tag;
      odata_d  = bus.core_out_data;
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + IW'(1);
      2'b01:   cnt_d = cnt_q - IW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    coll_d = coll_q;
    if (bus.coll_clr) begin
      coll_d = '0;
    end else if (bus.core_coll_irq && (coll_q != 8'hFF)) begin
      coll_d = coll_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge kill) begin
    if (kill) begin
      gap_q      <= '0;
      rr_last_q  <= 1'b1;
      cnt_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cin_en_q   <= 1'b0;
      cin_data_q <= '0;
      ov0_q      <= 1'b0;
      ov1_q      <= 1'b0;
      odata_q    <= '0;
      coll_q     <= '0;
      orphan_q   <= 1'b0;
      for (int i = 0; i < MAX_INFLIGHT; i++) begin
        tag_q[i] <= 1'b0;
      end
    end else begin
      gap_q      <= gap_d;
      rr_last_q  <= rr_last_d;
      cnt_q      <= cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cin_en_q   <= cin_en_d;
      cin_data_q <= cin_data_d;
      ov0_q      <= ov0_d;
      ov1_q      <= ov1_d;
      odata_q    <= odata_d;
      coll_q     <= coll_d;
      orphan_q   <= orphan_d;
      if (push) begin
        tag_q[wr_ptr_q] <= grant_1;
      end
    end
  end

  assign bus.in_ready_0   = can_issue & grant_0;
  assign bus.in_ready_1   = can_issue & grant_1;
  assign bus.core_in_en   = cin_en_q;
  assign bus.core_in_data = cin_data_q;
  assign bus.out_valid_0  = ov0_q;
  assign bus.out_valid_1  = ov1_q;
  assign bus.out_data     = odata_q;
  assign bus.inflight     = cnt_q;
  assign bus.coll_cnt     = coll_q;
  assign bus.orphan_err   = orphan_q;
endmodule
`default_nettype wire

// File: tb/tb_aes_128_issue_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_aes_128_issue_sched : directed bench with a cycle-level reference     |
// | model of the scheduler and a simple fixed-latency core.  Rev 1.0         |
// +--------------------------------------------------------------------------+
module tb_aes_128_issue_sched;
  localparam int ISSUE_GAP    = 12;
  localparam int MAX_INFLIGHT = 8;
  localparam int CORE_LAT     = 4;

  logic clk  = 1'b0;
  logic kill = 1'b1;
  always #5 clk = ~clk;

  aes_128_issue_sched_if #(.MAX_INFLIGHT(MAX_INFLIGHT)) bus ();

  aes_128_issue_sched #(
    .ISSUE_GAP    (ISSUE_GAP),
    .MAX_INFLIGHT (MAX_INFLIGHT)
  ) dut (
    .clk  (clk),
    .kill (kill),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: issue allowed once ISSUE_GAP edges have passed since the last one.
  int           since = ISSUE_GAP;
  bit           rr_last = 1'b1;
  int           tagq[$];
  int           glog[$];
  bit           e_cin_en;
  logic [127:0] e_cin_data;
  bit           e_ov0, e_ov1;
  logic [127:0] e_odata;
  bit           e_orphan;
  int           e_coll;
  int           e_inflight;
  bit           m_can, m_g1;
  int           m_tag;

  always @(negedge clk) begin
    if (kill) begin
      since = ISSUE_GAP; rr_last = 1'b1; tagq.delete();
      e_cin_en = 0; e_cin_data = '0; e_ov0 = 0; e_ov1 = 0; e_odata = '0;
      e_orphan = 0; e_coll = 0; e_inflight = 0;
      chk("kill_in_ready_0", 128'(bus.in_ready_0), 128'(0));
      chk("kill_in_ready_1", 128'(bus.in_ready_1), 128'(0));
      chk("kill_core_in_en", 128'(bus.core_in_en), 128'(0));
      chk("kill_core_in_data", bus.core_in_data, 128'(0));
      chk("kill_out_valid", {bus.out_valid_0, bus.out_valid_1}, 128'(0));
      chk("kill_out_data", bus.out_data, 128'(0));
      chk("kill_inflight", 128'(bus.inflight), 128'(0));
      chk("kill_coll_cnt", 128'(bus.coll_cnt), 128'(0));
      chk("kill_orphan_err", 128'(bus.orphan_err), 128'(0));
    end else begin
      chk("core_in_en", 128'(bus.core_in_en), 128'(e_cin_en));
      chk("core_in_data", bus.core_in_data, e_cin_data);
      chk("out_valid_0", 128'(bus.out_valid_0), 128'(e_ov0));
      chk("out_valid_1", 128'(bus.out_valid_1), 128'(e_ov1));
      chk("out_data", bus.out_data, e_odata);
      chk("inflight", 128'(bus.inflight), 128'(e_inflight));
      chk("coll_cnt", 128'(bus.coll_cnt), 128'(e_coll));
      chk("orphan_err", 128'(bus.orphan_err), 128'(e_orphan));

      m_can = bus.key_ready && (since >= ISSUE_GAP - 1) && (tagq.size() < MAX_INFLIGHT)
              && (bus.in_valid_0 || bus.in_valid_1);
      m_g1  = bus.in_valid_1 && (!bus.in_valid_0 || !rr_last);
      chk("in_ready_0", 128'(bus.in_ready_0), 128'(m_can && !m_g1));
      chk("in_ready_1", 128'(bus.in_ready_1), 128'(m_can && m_g1));

      e_ov0 = 0; e_ov1 = 0;
      if (bus.core_out_en) begin
        if (tagq.size() > 0) begin
          m_tag = tagq.pop_front();
          e_ov0 = (m_tag == 0); e_ov1 = (m_tag == 1);
          e_odata = bus.core_out_data;
        end else begin
          e_orphan = 1;
        end
      end
      if (m_can) begin
        tagq.push_back(int'(m_g1));
        glog.push_back(int'(m_g1));
        e_cin_en = 1; e_cin_data = m_g1 ? bus.in_data_1 : bus.in_data_0;
        rr_last = m_g1; since = 0;
      end else begin
        e_cin_en = 0;
        if (since < 100000) since++;
      end
      e_inflight = tagq.size();
      if (bus.coll_clr) e_coll = 0;
      else if (bus.core_coll_irq) e_coll = (e_coll >= 255) ? 255 : e_coll + 1;
    end
  end

  // Fixed-latency stand-in for the AES core; manual mode lets the stimulus force strobes.
  bit           core_auto = 1'b1;
  bit           man_en    = 1'b0;
  logic [127:0] man_data  = '0;
  logic [127:0] pend_d[$];
  int           pend_t[$];
  int           cyc = 0;

  initial begin
    bus.core_out_en = 1'b0;
    bus.core_out_data = '0;
  end

  always @(posedge clk) begin
    #2;
    cyc++;
    if (kill) begin
      pend_d.delete(); pend_t.delete();
    end else if (bus.core_in_en && core_auto) begin
      pend_d.push_back({bus.core_in_data[63:0], bus.core_in_data[127:64]} ^ 128'h5A5A_0000_FFFF_1234_0F0F_8888_C3C3_7777);
      pend_t.push_back(cyc + CORE_LAT);
    end
    if (man_en) begin
      bus.core_out_en = 1'b1; bus.core_out_data = man_data;
    end else if (core_auto && pend_t.size() > 0 && pend_t[0] <= cyc) begin
      bus.core_out_en = 1'b1; bus.core_out_data = pend_d.pop_front();
      void'(pend_t.pop_front());
    end else begin
      bus.core_out_en = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int base;
  int zeros;

  initial begin
    bus.in_valid_0 = 0; bus.in_valid_1 = 0;
    bus.in_data_0 = '0; bus.in_data_1 = '0;
    bus.key_ready = 1; bus.core_coll_irq = 0; bus.coll_clr = 0;
    step(3);
    kill = 0;

    // Single channel: one issue every ISSUE_GAP cycles, starting immediately.
    base = glog.size();
    bus.in_valid_0 = 1;
    for (int i = 0; i < 40; i++) begin
      bus.in_data_0 = {32'hC0DE_0000 + 32'(i), 96'h1111_2222_3333_4444_5555_6666};
      step(1);
    end
    bus.in_valid_0 = 0;
    chk("ch0_issue_count", 128'(glog.size() - base), 128'(4));
    step(12);

    // Both channels: alternate starting with ch0 after reset.
    kill = 1; step(2); kill = 0;
    base = glog.size();
    bus.in_valid_0 = 1; bus.in_valid_1 = 1;
    for (int i = 0; i < 50; i++) begin
      bus.in_data_0 = {64'hAAAA_0000_0000_0000 + 64'(i), 64'h0};
      bus.in_data_1 = {64'h0, 64'hBBBB_0000_0000_0000 + 64'(i)};
      step(1);
    end
    bus.in_valid_0 = 0; bus.in_valid_1 = 0;
    chk("rr_grant_0", 128'(glog[base]), 128'(0));
    chk("rr_grant_1", 128'(glog[base+1]), 128'(1));
    chk("rr_grant_2", 128'(glog[base+2]), 128'(0));
    chk("rr_grant_3", 128'(glog[base+3]), 128'(1));
    step(10);

    // Core withholds results: fill to MAX_INFLIGHT then one return frees a slot.
    kill = 1; step(2); kill = 0;
    core_auto = 0;
    base = glog.size();
    bus.in_valid_0 = 1; bus.in_data_0 = 128'hF00D;
    step(110);
    chk("full_issue_count", 128'(glog.size() - base), 128'(8));
    chk("full_inflight", 128'(bus.inflight), 128'(8));
    man_data = 128'hDEAD_BEEF; man_en = 1; bus.in_valid_1 = 1; bus.in_data_1 = 128'hBEEF;
    step(1);
    man_en = 0;
    step(3);
    bus.in_valid_0 = 0; bus.in_valid_1 = 0;
    chk("resume_issue_count", 128'(glog.size() - base), 128'(9));
    chk("resume_inflight", 128'(bus.inflight), 128'(8));

    // key_ready low blocks issue; raising it issues at once; orphan result.
    kill = 1; step(2); kill = 0;
    core_auto = 1;
    base = glog.size();
    bus.key_ready = 0; bus.in_valid_1 = 1; bus.in_data_1 = 128'h1234_5678;
    step(20);
    chk("keyoff_no_issue", 128'(glog.size() - base), 128'(0));
    bus.key_ready = 1;
    step(1);
    bus.in_valid_1 = 0;
    chk("keyon_issue", 128'(glog.size() - base), 128'(1));
    step(10);
    man_data = 128'h0BAD; man_en = 1;
    step(1);
    man_en = 0;
    step(2);
    chk("orphan_set", 128'(bus.orphan_err), 128'(1));

    // Kill mid-run with a block in flight.
    bus.in_valid_0 = 1; bus.in_data_0 = 128'h7777;
    step(2);
    chk("pre_kill_inflight", 128'(bus.inflight), 128'(1));
    kill = 1;
    #1;
    chk("kill_now_inflight", 128'(bus.inflight), 128'(0));
    chk("kill_now_orphan", 128'(bus.orphan_err), 128'(0));
    chk("kill_now_core_in_en", 128'(bus.core_in_en), 128'(0));
    bus.in_valid_0 = 0;
    step(2); kill = 0;
    step(2);

    // Collision counter saturation and clear priority.
    bus.core_coll_irq = 1;
    step(300);
    chk("coll_saturate", 128'(bus.coll_cnt), 128'(255));
    bus.coll_clr = 1;
    step(1);
    bus.coll_clr = 0; bus.core_coll_irq = 0;
    chk("coll_clear", 128'(bus.coll_cnt), 128'(0));
    step(3);

    zeros = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
`default_nettype wire
